// File: rtl/sr_latch_driver_pkg.sv
// Shared definitions for the sr_latch_driver slice.
//   state_t   : FSM state encoding (IDLE, PULSE_S, PULSE_R, GUARD)
//   cnt_width : bit width that can hold values 0..max_val inclusive
package sr_drv_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        PULSE_S = 2'd1,
        PULSE_R = 2'd2,
        GUARD   = 2'd3
    } state_t;

    // A zero limit still needs a 1-bit counter so the declarations stay legal.
    function automatic int cnt_width(input int max_val);
        int w;
        w = $clog2(max_val + 1);
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/sr_latch_driver_if.sv
// Request/drive bundle between the request source and sr_latch_driver.
//   set_req_in, rst_req_in : raw, asynchronous, bouncy request levels
//   S, R                   : registered drives to the downstream sr_latch
//   busy                   : a pulse or its guard gap is in progress
//   conflict, drop         : one-cycle registered event flags
// Signalling: there is no valid/ready pair. Requests are plain levels that
// the driver samples every clock; every output is a flop output that changes
// only on the rising clock edge, and the latch side has no back-pressure.
interface sr_latch_driver_if;

    logic set_req_in;
    logic rst_req_in;
    logic S;
    logic R;
    logic busy;
    logic conflict;
    logic drop;

    modport master (
        output set_req_in, rst_req_in,
        input  S, R, busy, conflict, drop
    );

    modport slave (
        input  set_req_in, rst_req_in,
        output S, R, busy, conflict, drop
    );

endinterface

// File: rtl/sr_latch_driver_debounce.sv
// sr_debounce: 2-flop synchroniser, debounce counter and rising-edge detect
// for one raw request line.
//   clk, rst_n : clock, synchronous active-low reset
//   raw_in     : asynchronous raw request level
//   rise       : one-cycle registered pulse when the debounced level goes 0->1
module sr_debounce
    import sr_drv_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic raw_in,
    output logic rise
);

    localparam int            CW       = cnt_width(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic          meta_q,   meta_d;
    logic          sync_q,   sync_d;
    logic          stable_q, stable_d;
    logic          rise_q,   rise_d;
    logic [CW-1:0] cnt_q,    cnt_d;

    // The counter holds the number of edges sync has already disagreed with
    // stable; the edge that would make it DEBOUNCE_CYCLES flips stable
    // instead, so it never exceeds CNT_LAST and never wraps.
    always_comb begin
        meta_d   = raw_in;
        sync_d   = meta_q;
        stable_d = stable_q;
        cnt_d    = '0;
        rise_d   = 1'b0;
        if (sync_q != stable_q) begin
            if (cnt_q >= CNT_LAST) begin
                stable_d = sync_q;
                rise_d   = sync_q;
            end else begin
                cnt_d = cnt_q + CW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            meta_q   <= 1'b0;
            sync_q   <= 1'b0;
            stable_q <= 1'b0;
            rise_q   <= 1'b0;
            cnt_q    <= '0;
        end else begin
            meta_q   <= meta_d;
            sync_q   <= sync_d;
            stable_q <= stable_d;
            rise_q   <= rise_d;
            cnt_q    <= cnt_d;
        end
    end

    assign rise = rise_q;

endmodule

// File: rtl/sr_latch_driver.sv
// sr_latch_driver: turns two debounced request lines into fixed-width S/R
// pulses for an sr_latch, each followed by a guard gap. S and R can never be
// high together; simultaneous requests raise conflict, requests while busy
// raise drop and are discarded.
//   clk, rst_n : clock, synchronous active-low reset
//   bus        : sr_latch_driver_if slave (requests in, S/R/flags out)
//   dbg_state  : current FSM state
module sr_latch_driver
    import sr_drv_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int PULSE_CYCLES    = 2,
    parameter int GUARD_CYCLES    = 1
) (
    input  logic                clk,
    input  logic                rst_n,
    sr_latch_driver_if.slave    bus,
    output state_t              dbg_state
);

    localparam int            PG_MAX     = (PULSE_CYCLES > GUARD_CYCLES) ? PULSE_CYCLES : GUARD_CYCLES;
    localparam int            CW         = cnt_width(PG_MAX);
    localparam logic [CW-1:0] PULSE_LAST = CW'(PULSE_CYCLES - 1);
    // Unused when GUARD_CYCLES is 0 because GUARD is then never entered.
    localparam logic [CW-1:0] GUARD_LAST = CW'(GUARD_CYCLES - 1);

    logic rise_s;
    logic rise_r;

    sr_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_set (
        .clk    (clk),
        .rst_n  (rst_n),
        .raw_in (bus.set_req_in),
        .rise   (rise_s)
    );

    sr_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_rst (
        .clk    (clk),
        .rst_n  (rst_n),
        .raw_in (bus.rst_req_in),
        .rise   (rise_r)
    );

    state_t        state_q,    state_d;
    logic [CW-1:0] cnt_q,      cnt_d;
    logic          s_q,        s_d;
    logic          r_q,        r_d;
    logic          busy_q,     busy_d;
    logic          conflict_q, conflict_d;
    logic          drop_q,     drop_d;

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        conflict_d = 1'b0;
        drop_d     = 1'b0;
        case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (rise_s && rise_r) begin
                    conflict_d = 1'b1;
                end else if (rise_s) begin
                    state_d = PULSE_S;
                end else if (rise_r) begin
                    state_d = PULSE_R;
                end
            end
            PULSE_S, PULSE_R: begin
                drop_d = rise_s | rise_r;
                if (cnt_q >= PULSE_LAST) begin
                    cnt_d   = '0;
                    state_d = (GUARD_CYCLES == 0) ? IDLE : GUARD;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            GUARD: begin
                drop_d = rise_s | rise_r;
                if (cnt_q >= GUARD_LAST) begin
                    cnt_d   = '0;
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            default: begin
                cnt_d   = '0;
                state_d = IDLE;
            end
        endcase
        // Outputs are decoded from the next state so they register in step
        // with the state they describe.
        s_d    = (state_d == PULSE_S);
        r_d    = (state_d == PULSE_R);
        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            s_q        <= 1'b0;
            r_q        <= 1'b0;
            busy_q     <= 1'b0;
            conflict_q <= 1'b0;
            drop_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            s_q        <= s_d;
            r_q        <= r_d;
            busy_q     <= busy_d;
            conflict_q <= conflict_d;
            drop_q     <= drop_d;
        end
    end

    assign bus.S        = s_q;
    assign bus.R        = r_q;
    assign bus.busy     = busy_q;
    assign bus.conflict = conflict_q;
    assign bus.drop     = drop_q;
    assign dbg_state    = state_q;

endmodule

// File: tb/tb_sr_latch_driver.sv
// Testbench for sr_latch_driver with D=4, P=2, G=1.
module tb_sr_latch_driver;
    import sr_drv_pkg::*;

    localparam int D = 4;
    localparam int P = 2;
    localparam int G = 1;

    // ---------------- clock / reset ----------------
    logic   clk   = 1'b0;
    logic   rst_n = 1'b0;
    state_t dbg_state;

    always #5 clk = ~clk;

    sr_latch_driver_if bus ();

    sr_latch_driver #(
        .DEBOUNCE_CYCLES (D),
        .PULSE_CYCLES    (P),
        .GUARD_CYCLES    (G)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .bus       (bus),
        .dbg_state (dbg_state)
    );

    int n_checks = 0;
    int n_pass   = 0;
    bit chk_en   = 1'b0;
    int se       = -1;   // index of the last scenario edge passed

    task automatic check1(input string name, input logic act, input logic exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s at %0t: got %b expected %b", name, $time, act, exp);
    endtask

    task automatic check_int(input string name, input int act, input int exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
    endtask

    // ---------------- behavioural model ----------------
    // sync after edge e is the raw level sampled at edge e-1; the debounced
    // level flips once sync has disagreed with it on D consecutive edges; a
    // 0->1 flip is a request seen by the sequencer at the following edge.
    // A started pulse lives P+G edges from its start edge.
    bit m_last_raw [2];
    bit m_sync     [2];
    bit m_stab     [2];
    bit m_rise     [2];
    int m_streak   [2];
    bit m_active;
    bit m_kind;        // 0 = set pulse, 1 = reset pulse
    int m_t;
    bit m_conflict;
    bit m_drop;
    bit m_rst_edge;

    always @(posedge clk) begin
        bit raw0, raw1, req0, req1;
        raw0 = bus.set_req_in;
        raw1 = bus.rst_req_in;
        if (!rst_n) begin
            for (int ch = 0; ch < 2; ch++) begin
                m_last_raw[ch] = 0; m_sync[ch] = 0; m_stab[ch] = 0;
                m_rise[ch] = 0; m_streak[ch] = 0;
            end
            m_active = 0; m_kind = 0; m_t = 0;
            m_conflict = 0; m_drop = 0; m_rst_edge = 1;
        end else begin
            m_rst_edge = 0;
            req0 = m_rise[0];
            req1 = m_rise[1];
            for (int ch = 0; ch < 2; ch++) begin
                m_rise[ch] = 0;
                if (m_sync[ch] != m_stab[ch]) begin
                    m_streak[ch]++;
                    if (m_streak[ch] == D) begin
                        m_stab[ch]   = m_sync[ch];
                        m_rise[ch]   = m_sync[ch];
                        m_streak[ch] = 0;
                    end
                end else begin
                    m_streak[ch] = 0;
                end
            end
            m_sync[0] = m_last_raw[0];  m_last_raw[0] = raw0;
            m_sync[1] = m_last_raw[1];  m_last_raw[1] = raw1;
            m_conflict = 0;
            m_drop     = 0;
            if (m_active) begin
                if (req0 || req1) m_drop = 1;
                m_t++;
                if (m_t == P + G) m_active = 0;
            end else if (req0 && req1) begin
                m_conflict = 1;
            end else if (req0 || req1) begin
                m_active = 1;
                m_kind   = req1;
                m_t      = 0;
            end
        end
    end

    // ---------------- compare process ----------------
    int s_run = 0, r_run = 0, gap = 0;
    bit have_end = 0, prev_any = 0;

    always @(negedge clk) begin
        logic   exp_s, exp_r, any;
        state_t exp_st;
        if (chk_en) begin
            exp_s  = m_active && !m_kind && (m_t < P);
            exp_r  = m_active &&  m_kind && (m_t < P);
            exp_st = !m_active ? IDLE : (m_t >= P) ? GUARD : (m_kind ? PULSE_R : PULSE_S);
            check1("S",        bus.S,        exp_s);
            check1("R",        bus.R,        exp_r);
            check1("busy",     bus.busy,     m_active);
            check1("conflict", bus.conflict, m_conflict);
            check1("drop",     bus.drop,     m_drop);
            check1("state",    dbg_state == exp_st, 1'b1);
            check1("s_and_r",  bus.S & bus.R, 1'b0);
            any = bus.S | bus.R;
            if (m_rst_edge) begin
                s_run = 0; r_run = 0; gap = 0; have_end = 0;
            end else begin
                if (any && !prev_any && have_end) check1("guard_gap", gap >= G, 1'b1);
                if (bus.S) s_run++;
                else if (s_run != 0) begin
                    check_int("s_width", s_run, P);
                    s_run = 0; have_end = 1; gap = 0;
                end
                if (bus.R) r_run++;
                else if (r_run != 0) begin
                    check_int("r_width", r_run, P);
                    r_run = 0; have_end = 1; gap = 0;
                end
                if (!any) gap++;
            end
            prev_any = any;
        end
    end

    // ---------------- driver tasks ----------------
    // Called at a negedge; returns at the negedge right after scenario edge e.
    task automatic goto_after(input int e);
        repeat (e - se) @(posedge clk);
        @(negedge clk);
        se = e;
    endtask

    task automatic quiet(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic release_all(input int n);
        bus.set_req_in = 1'b0;
        bus.rst_req_in = 1'b0;
        quiet(n);
    endtask

    // ---------------- directed scenarios ----------------
    initial begin
        bus.set_req_in = 1'b0;
        bus.rst_req_in = 1'b0;
        rst_n = 1'b0;
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        chk_en = 1'b1;
        check1("rst_S",        bus.S,        1'b0);
        check1("rst_R",        bus.R,        1'b0);
        check1("rst_busy",     bus.busy,     1'b0);
        check1("rst_conflict", bus.conflict, 1'b0);
        check1("rst_drop",     bus.drop,     1'b0);
        check1("rst_state",    dbg_state == IDLE, 1'b1);
        rst_n = 1'b1;
        quiet(3);

        // set held high: S after e6,e7; busy e6..e8
        se = -1; bus.set_req_in = 1'b1;
        goto_after(5); check1("s1_S_e5", bus.S, 1'b0);
        goto_after(6); check1("s1_S_e6", bus.S, 1'b1); check1("s1_busy_e6", bus.busy, 1'b1);
        check1("s1_R_e6", bus.R, 1'b0);
        goto_after(7); check1("s1_S_e7", bus.S, 1'b1);
        goto_after(8); check1("s1_S_e8", bus.S, 1'b0); check1("s1_busy_e8", bus.busy, 1'b1);
        goto_after(9); check1("s1_busy_e9", bus.busy, 1'b0);
        release_all(12);

        // reset-request glitch of 3 cycles: filtered
        se = -1; bus.rst_req_in = 1'b1;
        goto_after(2); bus.rst_req_in = 1'b0;
        goto_after(6); check1("g3_R_e6", bus.R, 1'b0);
        goto_after(8); check1("g3_busy_e8", bus.busy, 1'b0);
        release_all(10);

        // reset-request glitch of 5 cycles: one R pulse, same latency as S
        se = -1; bus.rst_req_in = 1'b1;
        goto_after(4); bus.rst_req_in = 1'b0;
        goto_after(5); check1("g5_R_e5", bus.R, 1'b0);
        goto_after(6); check1("g5_R_e6", bus.R, 1'b1); check1("g5_busy_e6", bus.busy, 1'b1);
        goto_after(7); check1("g5_R_e7", bus.R, 1'b1);
        goto_after(8); check1("g5_R_e8", bus.R, 1'b0); check1("g5_S_e8", bus.S, 1'b0);
        release_all(15);

        // both requests together: conflict for exactly one cycle at e6
        se = -1; bus.set_req_in = 1'b1; bus.rst_req_in = 1'b1;
        goto_after(5); check1("cf_e5", bus.conflict, 1'b0);
        goto_after(6); check1("cf_e6", bus.conflict, 1'b1);
        check1("cf_S_e6", bus.S, 1'b0); check1("cf_R_e6", bus.R, 1'b0);
        check1("cf_busy_e6", bus.busy, 1'b0);
        goto_after(7); check1("cf_e7", bus.conflict, 1'b0);
        release_all(12);

        // reset request one cycle behind set: dropped during PULSE_S
        se = -1; bus.set_req_in = 1'b1;
        goto_after(0); bus.rst_req_in = 1'b1;
        goto_after(6); check1("ov_S_e6", bus.S, 1'b1); check1("ov_drop_e6", bus.drop, 1'b0);
        goto_after(7); check1("ov_S_e7", bus.S, 1'b1); check1("ov_drop_e7", bus.drop, 1'b1);
        goto_after(8); check1("ov_S_e8", bus.S, 1'b0); check1("ov_drop_e8", bus.drop, 1'b0);
        check1("ov_R_e8", bus.R, 1'b0);
        goto_after(10); check1("ov_R_e10", bus.R, 1'b0);
        release_all(12);

        // reset mid-pulse at e7, input still held: fresh pulse after e14
        se = -1; bus.set_req_in = 1'b1;
        goto_after(6); check1("mr_S_e6", bus.S, 1'b1);
        rst_n = 1'b0;
        goto_after(7); check1("mr_S_e7", bus.S, 1'b0); check1("mr_busy_e7", bus.busy, 1'b0);
        rst_n = 1'b1;
        goto_after(13); check1("mr_S_e13", bus.S, 1'b0);
        goto_after(14); check1("mr_S_e14", bus.S, 1'b1);
        goto_after(15); check1("mr_S_e15", bus.S, 1'b1);
        goto_after(16); check1("mr_S_e16", bus.S, 1'b0);
        release_all(12);

        // reset request arriving while in GUARD: dropped
        se = -1; bus.set_req_in = 1'b1;
        goto_after(2); bus.rst_req_in = 1'b1;
        goto_after(9); check1("gd_drop_e9", bus.drop, 1'b1); check1("gd_R_e9", bus.R, 1'b0);
        goto_after(10); check1("gd_drop_e10", bus.drop, 1'b0); check1("gd_R_e10", bus.R, 1'b0);
        release_all(12);

        // reset request arriving the cycle the FSM is back in IDLE: accepted
        se = -1; bus.set_req_in = 1'b1;
        goto_after(3); bus.rst_req_in = 1'b1;
        goto_after(9); check1("ac_R_e9", bus.R, 1'b0); check1("ac_drop_e9", bus.drop, 1'b0);
        goto_after(10); check1("ac_R_e10", bus.R, 1'b1); check1("ac_drop_e10", bus.drop, 1'b0);
        goto_after(11); check1("ac_R_e11", bus.R, 1'b1);
        goto_after(12); check1("ac_R_e12", bus.R, 1'b0); check1("ac_busy_e12", bus.busy, 1'b1);
        goto_after(13); check1("ac_busy_e13", bus.busy, 1'b0);
        release_all(12);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
